// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the fetch/flag stage: FSM states, PC width, branch-target ROM.
`default_nettype none
package definitions;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  localparam int PC_W_DEFAULT      = 10;
  localparam int LUT_DEPTH_DEFAULT = 16;
  localparam int LUT_WORD_W        = 16;

  // Words wider than the PC are truncated on lookup (entries 14 and 15 rely on this).
  localparam logic [LUT_WORD_W-1:0] BRANCH_ROM [LUT_DEPTH_DEFAULT] = '{
    16'h0000, 16'h0020, 16'h0040, 16'h0080,
    16'h0100, 16'h0155, 16'h01FF, 16'h0200,
    16'h02AA, 16'h0300, 16'h0333, 16'h03F0,
    16'h0010, 16'h00C0, 16'hFC21, 16'hF3FF
  };

endpackage
`default_nettype wire

// File: rtl/fetch_ctrl_branch_lut.sv
// Combinational branch-target ROM: maps a LUT index to a PC_W-wide jump/branch target.
`default_nettype none
module branch_lut
  import definitions::*;
#(
  parameter int PC_W      = PC_W_DEFAULT,
  parameter int LUT_DEPTH = LUT_DEPTH_DEFAULT
) (
  input  logic [$clog2(LUT_DEPTH)-1:0] idx,
  output logic [PC_W-1:0]              target
);

  logic [LUT_WORD_W-1:0] word;

  assign word   = BRANCH_ROM[idx];
  assign target = word[PC_W-1:0];

endmodule
`default_nettype wire

// File: rtl/fetch_ctrl.sv
// Program sequencer and ALU flag stage: PC, run/halt FSM, zero/carry flags, LUT-resolved jumps and branches.
`default_nettype none
module fetch_ctrl
  import definitions::*;
#(
  parameter int PC_W      = PC_W_DEFAULT,
  parameter int LUT_DEPTH = LUT_DEPTH_DEFAULT
) (
  input  logic                         CLK,
  input  logic                         Reset,
  input  logic                         start,
  input  logic [PC_W-1:0]              start_addr,
  input  logic                         halt_req,
  input  logic                         stall,
  input  logic                         jump_en,
  input  logic                         branch_en,
  input  logic [$clog2(LUT_DEPTH)-1:0] target_idx,
  input  logic                         zero_we,
  input  logic                         zero_in,
  input  logic                         carry_we,
  input  logic                         carry_clr,
  input  logic                         carry_in,
  output logic [PC_W-1:0]              pc,
  output logic                         fetch_valid,
  output logic                         carry_q,
  output logic                         zero_q,
  output logic                         done
);

  fetch_state_t    state;
  logic [PC_W-1:0] lut_target;
  logic [PC_W-1:0] next_pc;

  branch_lut #(
    .PC_W      (PC_W),
    .LUT_DEPTH (LUT_DEPTH)
  ) u_branch_lut (
    .idx    (target_idx),
    .target (lut_target)
  );

  // Branch tests the registered zero flag, so a same-cycle zero_we is seen one instruction later.
  always_comb begin
    next_pc = pc + PC_W'(1);
    if (jump_en || (branch_en && zero_q)) begin
      next_pc = lut_target;
    end
  end

  assign fetch_valid = (state == RUN);

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state   <= IDLE;
      pc      <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      done    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            pc    <= start_addr;
          end
        end
        RUN: begin
          if (halt_req) begin
            state <= HALTED;
            done  <= 1'b1;
          end else if (!stall) begin
            pc <= next_pc;
          end
          // Flag capture is independent of halt_req; only stall suppresses it.
          if (!stall) begin
            if (zero_we) begin
              zero_q <= zero_in;
            end
            if (carry_clr) begin
              carry_q <= 1'b0;
            end else if (carry_we) begin
              carry_q <= carry_in;
            end
          end
        end
        HALTED: begin
          if (start) begin
            state <= RUN;
            pc    <= start_addr;
            done  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: behavioural model feeds a scoreboard queue, compared after each edge.
`default_nettype none
module tb_fetch_ctrl;

  logic       CLK = 1'b0;
  logic       Reset, start, halt_req, stall, jump_en, branch_en;
  logic [9:0] start_addr;
  logic [3:0] target_idx;
  logic       zero_we, zero_in, carry_we, carry_clr, carry_in;
  logic [9:0] pc;
  logic       fetch_valid, carry_q, zero_q, done;

  fetch_ctrl dut (
    .CLK         (CLK),
    .Reset       (Reset),
    .start       (start),
    .start_addr  (start_addr),
    .halt_req    (halt_req),
    .stall       (stall),
    .jump_en     (jump_en),
    .branch_en   (branch_en),
    .target_idx  (target_idx),
    .zero_we     (zero_we),
    .zero_in     (zero_in),
    .carry_we    (carry_we),
    .carry_clr   (carry_clr),
    .carry_in    (carry_in),
    .pc          (pc),
    .fetch_valid (fetch_valid),
    .carry_q     (carry_q),
    .zero_q      (zero_q),
    .done        (done)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       rst;
    logic       start;
    logic [9:0] sa;
    logic       halt;
    logic       stall;
    logic       jump;
    logic       br;
    logic [3:0] idx;
    logic       zwe;
    logic       zin;
    logic       cwe;
    logic       cclr;
    logic       cin;
  } stim_t;

  typedef struct packed {
    logic [9:0] pc;
    logic       fv;
    logic       c;
    logic       z;
    logic       done;
  } exp_t;

  localparam int S_IDLE = 0, S_RUN = 1, S_HALT = 2;

  logic [15:0] ref_lut [16] = '{
    16'h0000, 16'h0020, 16'h0040, 16'h0080,
    16'h0100, 16'h0155, 16'h01FF, 16'h0200,
    16'h02AA, 16'h0300, 16'h0333, 16'h03F0,
    16'h0010, 16'h00C0, 16'hFC21, 16'hF3FF
  };

  exp_t       sb [$];
  int         m_st;
  logic [9:0] m_pc;
  logic       m_z, m_c, m_done;
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [9:0] lut_tgt(input logic [3:0] i);
    logic [15:0] w;
    w = ref_lut[i];
    return w[9:0];
  endfunction

  task automatic model(input stim_t s);
    logic [9:0] pc_n;
    if (s.rst) begin
      m_st = S_IDLE; m_pc = '0; m_z = 1'b0; m_c = 1'b0; m_done = 1'b0;
    end else begin
      case (m_st)
        S_IDLE: if (s.start) begin m_st = S_RUN; m_pc = s.sa; end
        S_RUN: begin
          if (s.jump)             pc_n = lut_tgt(s.idx);
          else if (s.br && m_z)   pc_n = lut_tgt(s.idx);
          else                    pc_n = m_pc + 10'd1;
          if (s.halt) begin
            m_st = S_HALT; m_done = 1'b1;
          end else if (!s.stall) begin
            m_pc = pc_n;
          end
          if (!s.stall) begin
            if (s.zwe) m_z = s.zin;
            if (s.cclr) m_c = 1'b0;
            else if (s.cwe) m_c = s.cin;
          end
        end
        default: if (s.start) begin m_st = S_RUN; m_pc = s.sa; m_done = 1'b0; end
      endcase
    end
  endtask

  task automatic step(input stim_t s, input string tag);
    exp_t e;
    Reset = s.rst; start = s.start; start_addr = s.sa; halt_req = s.halt;
    stall = s.stall; jump_en = s.jump; branch_en = s.br; target_idx = s.idx;
    zero_we = s.zwe; zero_in = s.zin; carry_we = s.cwe; carry_clr = s.cclr;
    carry_in = s.cin;
    model(s);
    e.pc = m_pc; e.fv = (m_st == S_RUN); e.c = m_c; e.z = m_z; e.done = m_done;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    e = sb.pop_front();
    check({tag, ".pc"},    32'(pc),          32'(e.pc));
    check({tag, ".fv"},    32'(fetch_valid), 32'(e.fv));
    check({tag, ".carry"}, 32'(carry_q),     32'(e.c));
    check({tag, ".zero"},  32'(zero_q),      32'(e.z));
    check({tag, ".done"},  32'(done),        32'(e.done));
  endtask

  stim_t s;

  initial begin
    m_st = S_IDLE; m_pc = '0; m_z = 1'b0; m_c = 1'b0; m_done = 1'b0;

    s = '0; s.rst = 1'b1;
    step(s, "reset0");
    step(s, "reset1");

    // Reset mid-RUN with pc=5, carry=1
    s = '0; s.start = 1'b1; s.sa = 10'h004;            step(s, "start4");
    s = '0; s.cwe = 1'b1; s.cin = 1'b1;                 step(s, "carry_set");
    check("pre_rst_pc", 32'(pc), 32'h005);
    check("pre_rst_c",  32'(carry_q), 32'h1);
    s = '0; s.rst = 1'b1;                               step(s, "rst_midrun");
    check("rst_pc", 32'(pc), 32'h0);
    check("rst_fv", 32'(fetch_valid), 32'h0);

    // Sequential fetch
    s = '0; s.start = 1'b1; s.sa = 10'h010;            step(s, "start10");
    for (int i = 0; i < 4; i++) begin
      s = '0;                                           step(s, "seq");
    end
    check("seq_end", 32'(pc), 32'h014);
    s = '0; s.start = 1'b1; s.sa = 10'h200;            step(s, "start_ignored");

    // Taken branch
    s = '0; s.jump = 1'b1; s.idx = 4'd1;               step(s, "jump20");
    s = '0; s.zwe = 1'b1; s.zin = 1'b1;                 step(s, "zero_set");
    s = '0; s.br = 1'b1; s.idx = 4'd3;                 step(s, "br_taken");
    check("br_taken_pc", 32'(pc), 32'h080);
    // Not-taken branch
    s = '0; s.jump = 1'b1; s.idx = 4'd1;               step(s, "jump20b");
    s = '0; s.zwe = 1'b1; s.zin = 1'b0;                 step(s, "zero_clr");
    s = '0; s.br = 1'b1; s.idx = 4'd3;                 step(s, "br_nt");
    check("br_nt_pc", 32'(pc), 32'h022);
    // Branch sees old zero flag
    s = '0; s.br = 1'b1; s.idx = 4'd3; s.zwe = 1'b1; s.zin = 1'b1; step(s, "br_same");
    check("br_same_pc", 32'(pc), 32'h023);
    check("br_same_z",  32'(zero_q), 32'h1);

    // Carry priority and stall
    s = '0; s.cwe = 1'b1; s.cin = 1'b1;                 step(s, "carry1");
    s = '0; s.cwe = 1'b1; s.cclr = 1'b1; s.cin = 1'b1;  step(s, "carry_clr_pri");
    check("clr_pri_c", 32'(carry_q), 32'h0);
    s = '0; s.stall = 1'b1; s.cwe = 1'b1; s.cin = 1'b1; s.zwe = 1'b1; s.jump = 1'b1; step(s, "stall");
    check("stall_pc", 32'(pc), 32'h025);

    // Wrap, halt, restart
    s = '0; s.jump = 1'b1; s.idx = 4'd15;              step(s, "jump3ff");
    check("trunc_pc", 32'(pc), 32'h3FF);
    s = '0;                                             step(s, "wrap");
    check("wrap_pc", 32'(pc), 32'h000);
    s = '0; s.halt = 1'b1; s.zwe = 1'b1; s.zin = 1'b0; s.jump = 1'b1; step(s, "halt");
    check("halt_done", 32'(done), 32'h1);
    s = '0; s.jump = 1'b1; s.cwe = 1'b1; s.cin = 1'b1; step(s, "halted_hold");
    s = '0; s.start = 1'b1; s.sa = 10'h004;            step(s, "restart");
    check("restart_pc", 32'(pc), 32'h004);

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      s       = '0;
      s.rst   = ($urandom_range(0, 63) == 0);
      s.start = ($urandom_range(0, 7) == 0);
      s.sa    = 10'($urandom);
      s.halt  = ($urandom_range(0, 15) == 0);
      s.stall = ($urandom_range(0, 3) == 0);
      s.jump  = ($urandom_range(0, 7) == 0);
      s.br    = ($urandom_range(0, 3) == 0);
      s.idx   = 4'($urandom);
      s.zwe   = 1'($urandom);
      s.zin   = 1'($urandom);
      s.cwe   = 1'($urandom);
      s.cclr  = ($urandom_range(0, 3) == 0);
      s.cin   = 1'($urandom);
      step(s, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_ctrl.md
# fetch_ctrl

Program-sequencing and flag stage around the combinational ALU. It latches the ALU's ZERO and SC_OUT results into architectural flag registers and returns the carry flag to the ALU's SC_IN. It owns the program counter and a run/halt state machine, and resolves jumps and flag-conditioned branches through a small branch-target lookup table. It sits between the ALU outputs and instruction fetch, and closes the loop from compare result to next PC.

## Interface
Parameters:
- PC_W, 10, program counter width; instruction memory holds 2^PC_W words.
- LUT_DEPTH, 16, number of branch-target entries; index width is log2(LUT_DEPTH) = 4.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- start  in  1  begin program execution; level-sampled at each edge.
- start_addr  in  PC_W  PC value loaded on start.
- halt_req  in  1  decoder has decoded a halt instruction at the current PC.
- stall  in  1  hold PC and flags for this cycle.
- jump_en  in  1  unconditional jump at the current PC.
- branch_en  in  1  branch-if-zero-flag at the current PC.
- target_idx  in  4  branch-target LUT index for jump or branch.
- zero_we  in  1  capture ALU ZERO into the zero flag (compare/ALU op retired).
- zero_in  in  1  ALU ZERO output.
- carry_we  in  1  capture ALU SC_OUT into the carry flag.
- carry_clr  in  1  clear the carry flag.
- carry_in  in  1  ALU SC_OUT output.
- pc  out  PC_W  current instruction address.
- fetch_valid  out  1  pc addresses a live instruction (state RUN).
- carry_q  out  1  carry flag; drives ALU SC_IN.
- zero_q  out  1  zero flag.
- done  out  1  program reached halt.

## Operation
- States: IDLE, RUN, HALTED.
- Reset (any state, mid-operation included) forces IDLE, pc=0, zero_q=0, carry_q=0, done=0, fetch_valid=0.
- IDLE:
  - start=1 → RUN, pc<=start_addr.
  - Otherwise hold.
- RUN:
  - fetch_valid=1.
  - Next-PC priority per cycle: halt_req > stall > jump_en > (branch_en & zero_q) > pc+1.
  - halt_req → HALTED, done<=1, pc held.
  - stall → pc held; flag writes suppressed.
  - jump_en → pc<=lut[target_idx].
  - branch_en with zero_q=1 → pc<=lut[target_idx]; with zero_q=0 → pc+1.
  - start is ignored in RUN.
- HALTED:
  - fetch_valid=0, done=1.
  - start=1 → RUN, pc<=start_addr, done<=0.
- Flags update only in RUN with stall=0; halt_req does not block them.
  - zero_we → zero_q<=zero_in.
  - carry_clr → carry_q<=0; carry_clr has priority over carry_we.
  - carry_we → carry_q<=carry_in.
- Branch and zero_we in the same cycle: the branch evaluates the old registered zero_q. The new value is visible to the next instruction.
- PC arithmetic is modulo 2^PC_W: pc=2^PC_W-1 increments to 0.
- Out-of-range LUT index cannot occur (LUT_DEPTH=2^4). Entries wider than PC_W are truncated.

## Timing
- All outputs are registered except fetch_valid, which is decoded from state.
- Next-PC decision: 0-cycle combinational from inputs; pc updates on the following edge, so there is 1-cycle latency from an instruction to its successor address.
- Flag capture: 1 cycle. carry_q/zero_q change on the edge after a write-enable and are usable by the next instruction.
- Start to first fetch: 1 edge. HALTED→RUN restart behaves identically.
- done asserts on the edge that samples halt_req and stays high until start or Reset.

## Structure
- Shared `definitions` package:
  - fetch_state_t enum {IDLE, RUN, HALTED}.
  - PC_W default constant.
  - Branch-target ROM contents as a constant array of LUT_DEPTH words.
- One sub-module, branch_lut: combinational ROM taking target_idx and returning a PC_W target, initialised from the package constant.
- The state register, PC register, and flag registers stay in fetch_ctrl.

## Test plan
- Reset mid-RUN: pc=0x05, carry_q=1, then Reset=1 for one edge → pc=0, state IDLE, carry_q=0, zero_q=0, done=0, fetch_valid=0.
- start with start_addr=0x010, then 4 idle cycles in RUN → pc sequence 0x010,0x011,0x012,0x013,0x014; fetch_valid=1 throughout.
- zero_we=1, zero_in=1 at pc=0x020, then branch_en=1, target_idx=3 (lut[3]=0x080) → pc=0x080. Same scenario with zero_in=0 → pc=0x022.
- Branch and zero_we in the same cycle with old zero_q=0 and zero_in=1 → falls through to pc+1, and zero_q=1 afterwards.
- carry_we=1, carry_clr=1, carry_in=1 together → carry_q=0. Then stall=1 with carry_we=1 → carry_q and pc unchanged.
- pc=0x3FF, no control → pc=0x000. Then halt_req=1 → done=1, fetch_valid=0, pc held. Then start with start_addr=0x004 → RUN, pc=0x004, done=0.
